// File: rtl/alu_wide_seq_if.sv
// Request/response handshake bundle for alu_wide_seq.
// master = datapath control, slave = sequencer.
interface alu_wide_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_wide_seq.sv
// 16-bit add/sub/mul sequencer driving a shared 8-bit ALU.
// Chains carries between byte slices; MUL is 8-step shift-add.
package ALU_def;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_NEG  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_PASS = 4'd7
  } ALU_CTRL;
endpackage

module alu_wide_seq
  import ALU_def::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_wide_seq_if.slave  bus,
  output ALU_CTRL        alu_ctrl,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic           alu_cin,
  input  logic [7:0]     alu_out,
  input  logic           alu_cout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADD_LO,
    S_ADD_HI,
    S_NEG_LO,
    S_NEG_HI,
    S_SUB_LO,
    S_SUB_HI,
    S_MUL_ITER,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] nb_q, nb_d;
  logic [15:0] res_q, res_d;
  logic        chain_q, chain_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic [2:0]  cnt_q, cnt_d;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_DONE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_zero   = zero_q;

  // Next-state, datapath capture and ALU pin drive per state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    nb_d     = nb_q;
    res_d    = res_q;
    chain_d  = chain_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    alu_ctrl = ALU_ADD;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          cnt_d   = 3'd0;
          carry_d = 1'b0;
          unique case (bus.req_op)
            2'b00: state_d = S_ADD_LO;
            2'b01: state_d = S_NEG_LO;
            2'b10: begin
              res_d   = {8'h00, bus.req_b[7:0]};
              state_d = S_MUL_ITER;
            end
            default: begin
              res_d   = 16'h0000;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_ADD_LO: begin
        alu_ctrl    = ALU_ADD;
        alu_a       = a_q[7:0];
        alu_b       = b_q[7:0];
        res_d[7:0]  = alu_out;
        chain_d     = alu_cout;
        state_d     = S_ADD_HI;
      end
      S_ADD_HI: begin
        alu_ctrl    = ALU_ADDC;
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_cin     = chain_q;
        res_d[15:8] = alu_out;
        carry_d     = alu_cout;
        state_d     = S_DONE;
      end
      S_NEG_LO: begin
        alu_ctrl   = ALU_NEG;
        alu_a      = b_q[7:0];
        nb_d[7:0]  = alu_out;
        state_d    = S_NEG_HI;
      end
      S_NEG_HI: begin
        alu_ctrl   = ALU_NEG;
        alu_a      = b_q[15:8];
        nb_d[15:8] = alu_out;
        state_d    = S_SUB_LO;
      end
      S_SUB_LO: begin
        alu_ctrl   = ALU_ADDC;
        alu_a      = a_q[7:0];
        alu_b      = nb_q[7:0];
        alu_cin    = 1'b1;
        res_d[7:0] = alu_out;
        chain_d    = alu_cout;
        state_d    = S_SUB_HI;
      end
      S_SUB_HI: begin
        alu_ctrl    = ALU_ADDC;
        alu_a       = a_q[15:8];
        alu_b       = nb_q[15:8];
        alu_cin     = chain_q;
        res_d[15:8] = alu_out;
        carry_d     = alu_cout;
        state_d     = S_DONE;
      end
      S_MUL_ITER: begin
        alu_ctrl = ALU_ADD;
        alu_a    = res_q[15:8];
        alu_b    = res_q[0] ? a_q[7:0] : 8'h00;
        res_d    = {alu_cout, alu_out, res_q[7:1]};
        carry_d  = 1'b0;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE)
      zero_d = (res_d == 16'h0000);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      nb_q    <= 16'h0000;
      res_q   <= 16'h0000;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      nb_q    <= nb_d;
      res_q   <= res_d;
      chain_q <= chain_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Multi-cycle 16-bit arithmetic sequencer that drives the shared 8-bit ALU as its initiator. It accepts a 16-bit request over a valid/ready handshake and issues a sequence of 8-bit ALU operations, chaining carries between them. It returns a 16-bit result with carry and zero flags over a second valid/ready handshake. It sits between the datapath control and the combinational 8-bit ALU and owns the ALU's `ctrl_input`, `a`, `b` and `cin` pins while instantiated.

## Interface
- No parameters; datapath widths are fixed: 16-bit requests, 8-bit ALU.
- `clk` input 1: single clock. All state is updated on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: high only in IDLE; computed combinationally from state.
- `req_op` input 2: `00` ADD, `01` SUB, `10` MUL (8x8 unsigned), `11` reserved.
- `req_a`, `req_b` input 16: operands. MUL uses only bits [7:0].
- `rsp_valid` output 1: result is available.
- `rsp_ready` input 1: the consumer accepts the result.
- `rsp_result` output 16: the result.
- `rsp_carry` output 1: ADD carry-out; SUB no-borrow (1 when A>=B unsigned); 0 for MUL and reserved.
- `rsp_zero` output 1: `rsp_result == 16'h0000`, computed locally over all 16 bits.
- `alu_ctrl` output `ALU_CTRL` (package `ALU_def`): ALU operation select.
- `alu_a`, `alu_b` output 8: ALU operands.
- `alu_cin` output 1: ALU carry-in.
- `alu_out` input 8, `alu_cout` input 1: ALU results. The ALU is combinational, so results are captured on the same edge that ends the issuing state.

## Operation
- A request is accepted on `req_valid && req_ready`. `req_op`, `req_a` and `req_b` are latched into internal registers. Later changes on the request inputs have no effect.
- The block has the following states: IDLE, ADD_LO, ADD_HI, NEG_LO, NEG_HI, SUB_LO, SUB_HI, MUL_ITER, DONE.
- ADD: on accept, the block goes to ADD_LO.
  - ADD_LO issues `ALU_ADD` with A[7:0] and B[7:0]. It captures `res[7:0]` and the chain carry, then goes to ADD_HI.
  - ADD_HI issues `ALU_ADDC` with A[15:8], B[15:8] and `cin` = chain carry. It captures `res[15:8]`, sets `rsp_carry` = `alu_cout`, then goes to DONE.
- SUB: computes A + ~B + 1. `ALU_SUB` is not used because it gives no carry.
  - NEG_LO issues `ALU_NEG` with a=B[7:0] and captures nb_lo.
  - NEG_HI issues `ALU_NEG` with a=B[15:8] and captures nb_hi.
  - SUB_LO issues `ALU_ADDC` with A[7:0], nb_lo and cin=1.
  - SUB_HI issues `ALU_ADDC` with A[15:8], nb_hi and cin = chain carry. `rsp_carry` = final cout. The next state is DONE.
- MUL: shift-add over 8 iterations.
  - On accept, P_hi=0, P_lo=B[7:0] and the 3-bit counter is 0.
  - Each MUL_ITER cycle issues `ALU_ADD` with a=P_hi and b = P_lo[0] ? A[7:0] : 0.
  - On each edge: P_hi <= {alu_cout, alu_out[7:1]}, P_lo <= {alu_out[0], P_lo[7:1]}, and the counter increments.
  - After the iteration where the counter is 7, the block goes to DONE with result {P_hi, P_lo}.
- Reserved op `11`: goes directly to DONE with result 0, carry 0, zero 1.
- DONE: `rsp_valid`=1. `rsp_result`, `rsp_carry` and `rsp_zero` hold stable until `rsp_ready`. On `rsp_valid && rsp_ready` the block returns to IDLE.
- In any non-issuing state (IDLE, DONE), the ALU pins are driven to `ALU_ADD`, a=0, b=0, cin=0.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_result`=0, `rsp_carry`=0, `rsp_zero`=0, internal registers 0. `req_ready`=1 while in IDLE, including during reset.
- Latency is counted from the accepting edge to the edge after which `rsp_valid`=1:
  - ADD: 2
  - SUB: 4
  - MUL: 8
  - reserved: 0 (`rsp_valid` is high the cycle after accept)
- `req_ready`=0 from the accepting edge until the block is back in IDLE. A request presented while busy is held off and never dropped.
- Back-to-back: response handshake at edge t puts the block in IDLE after t, and the next accept occurs at t+1 at the earliest. There is a minimum of one IDLE cycle between jobs, and no request/response overlap.
- Backpressure: with `rsp_ready`=0 the block stays in DONE indefinitely with outputs frozen.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above. The in-flight job is discarded and produces no response.
- Carry chain: the chain carry register is written only by LO states. HI states read it on the cycle immediately following.

## Test plan
- ADD, two cases:
  - 0x00FF + 0x0001 -> 0x0100, carry 0, zero 0, `rsp_valid` 2 edges after accept.
  - 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1.
- SUB, two cases:
  - 0x1234 - 0x0235 -> 0x0FFF, carry 1.
  - 0x0001 - 0x0002 -> 0xFFFF, carry 0.
  - Both at latency 4. The ALU monitor must show NEG, NEG, ADDC(cin=1), ADDC.
- MUL, two cases:
  - A=0xABFF, B=0x12FF -> 0xFE01, carry 0. The upper bytes must be ignored.
  - 0x0000 * 0x0037 -> 0x0000, zero 1.
  - Latency 8, with exactly 8 `ALU_ADD` cycles observed.
- Handshake:
  - Hold `rsp_ready`=0 for 5 cycles after an ADD completes. Outputs must be stable and `req_ready`=0 throughout.
  - Keep `req_valid` high with a second request. It must be accepted exactly one cycle after the response handshake.
- Reserved op `11` with arbitrary operands -> 0x0000, carry 0, zero 1, `rsp_valid` the cycle after accept.
- Reset asserted asynchronously between edges during MUL iteration 4:
  - All outputs drop to their reset values immediately.
  - `req_ready`=1.
  - No `rsp_valid` follows.
  - A subsequent ADD 0x0003 + 0x0004 returns 0x0007.
